// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum byte stream, writes the payload into IMEM
// from address 0, and releases the core only after a checksum-valid image has landed.
module imem_loader #(
   parameter int MEM_NBYTE = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0] MAX_LEN = 32'(MEM_NBYTE);

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [31:0] len;
   logic [31:0] idx;
   logic [7:0]  sum;
   logic        hs;
   logic [31:0] len_next;

   assign s_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   assign hs       = s_valid && s_ready;
   // Length arrives LSB first, so shift each new byte in from the top.
   assign len_next = {s_data, len[31:8]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         byte_cnt <= 2'd0;
         len      <= 32'd0;
         idx      <= 32'd0;
         sum      <= 8'd0;
         wr_en    <= 1'b0;
         wr_addr  <= 32'd0;
         wr_data  <= 8'd0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN;
                  byte_cnt <= 2'd0;
                  len      <= 32'd0;
                  idx      <= 32'd0;
                  sum      <= 8'd0;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            S_LEN: begin
               if (hs) begin
                  len      <= len_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (len_next > MAX_LEN) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                     end else if (len_next == 32'd0) begin
                        state <= S_CSUM;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (hs) begin
                  wr_en   <= 1'b1;
                  wr_addr <= idx;
                  wr_data <= s_data;
                  sum     <= sum + s_data;
                  idx     <= idx + 32'd1;
                  if (idx == len - 32'd1) state <= S_CSUM;
               end
            end
            S_CSUM: begin
               if (hs) begin
                  if (s_data == sum) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/oversize errors, reset and reload.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst, start, s_valid;
   logic [7:0]  s_data;
   logic        s_ready, wr_en, cpu_hold, done, err;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] log_a[$];
   logic [7:0]  log_d[$];

   imem_loader #(.MEM_NBYTE(4096)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // A write pulse visible during a cycle is captured at the edge that ends it.
   always @(posedge clk) begin
      if (wr_en) begin
         log_a.push_back(wr_addr);
         log_d.push_back(wr_data);
      end
   end

   task automatic send(input logic [7:0] b);
      bit hs = 1'b0;
      int k = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (!hs && k < 20) begin
         @(posedge clk);
         hs = s_ready;
         @(negedge clk);
         k++;
      end
      if (!hs) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: byte %02h not accepted within 20 cycles", b);
      end
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] n);
      send(n[7:0]); send(n[15:8]); send(n[23:16]); send(n[31:24]);
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
      n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b exp 0", wr_en); end
      n_cmp++; if (wr_addr !== 32'd0) begin n_err++; $display("FAIL rst_wr_addr: got %0h exp 0", wr_addr); end
      n_cmp++; if (wr_data !== 8'd0) begin n_err++; $display("FAIL rst_wr_data: got %0h exp 0", wr_data); end
      n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL rst_cpu_hold: got %b exp 1", cpu_hold); end
      n_cmp++; if ({done, err} !== 2'b00) begin n_err++; $display("FAIL rst_done_err: got %b exp 00", {done, err}); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL idle_s_ready: got %b exp 0", s_ready); end
   endtask

   task automatic test_normal();
      logic [7:0] pay [4];
      pay = '{8'h13, 8'h00, 8'h00, 8'h00};
      pulse_start();
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL len_s_ready: got %b exp 1", s_ready); end
      send_len(32'd4);
      for (int i = 0; i < 4; i++) begin
         send(pay[i]);
         n_cmp++;
         if (wr_en !== 1'b1 || wr_addr !== 32'(i) || wr_data !== pay[i]) begin
            n_err++;
            $display("FAIL norm_write%0d: got en=%b addr=%0h data=%02h exp en=1 addr=%0h data=%02h",
                     i, wr_en, wr_addr, wr_data, i, pay[i]);
         end
      end
      n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL norm_hold_pre: got %b exp 1", cpu_hold); end
      send(8'h13);
      s_valid = 1'b0;
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL norm_done: got done=%b err=%b exp 1/0", done, err); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL norm_hold: got %b exp 0", cpu_hold); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL norm_s_ready: got %b exp 0", s_ready); end
      n_cmp++;
      if (wr_en !== 1'b0 || wr_addr !== 32'd3 || wr_data !== 8'h00) begin
         n_err++;
         $display("FAIL norm_hold_wr: got en=%b addr=%0h data=%02h exp 0/3/00", wr_en, wr_addr, wr_data);
      end
   endtask

   task automatic test_bad_csum();
      clear_log();
      pulse_start();
      n_cmp++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin n_err++; $display("FAIL reload_clear: got done=%b hold=%b exp 0/1", done, cpu_hold); end
      send_len(32'd4);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h14);
      idle(2);
      n_cmp++; if (log_a.size() !== 4) begin n_err++; $display("FAIL bad_writes: got %0d exp 4", log_a.size()); end
      n_cmp++; if ({err, done, cpu_hold} !== 3'b101) begin n_err++; $display("FAIL bad_flags: got err/done/hold=%b exp 101", {err, done, cpu_hold}); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bad_s_ready: got %b exp 0", s_ready); end
   endtask

   task automatic test_oversize();
      logic [7:0] sum = 8'd0;
      logic [7:0] d;
      int bad = 0;
      clear_log();
      pulse_start();
      send(8'h01); send(8'h10); send(8'h00); send(8'h00);
      s_valid = 1'b1; s_data = 8'h55;
      n_cmp++; if (err !== 1'b1 || cpu_hold !== 1'b1) begin n_err++; $display("FAIL over_err: got err=%b hold=%b exp 1/1", err, cpu_hold); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL over_s_ready: got %b exp 0", s_ready); end
      idle(3);
      n_cmp++; if (log_a.size() !== 0) begin n_err++; $display("FAIL over_writes: got %0d exp 0", log_a.size()); end
      // Largest legal image: exactly MEM_NBYTE bytes.
      clear_log();
      pulse_start();
      send(8'h00); send(8'h10); send(8'h00); send(8'h00);
      for (int i = 0; i < 4096; i++) begin
         d = 8'(i * 7 + 3);
         sum = sum + d;
         send(d);
      end
      send(sum);
      idle(2);
      n_cmp++; if (log_a.size() !== 4096) begin n_err++; $display("FAIL max_writes: got %0d exp 4096", log_a.size()); end
      for (int i = 0; i < log_a.size(); i++)
         if (log_a[i] !== 32'(i) || log_d[i] !== 8'(i * 7 + 3)) bad++;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL max_seq: got %0d bad entries exp 0", bad); end
      n_cmp++; if (wr_addr !== 32'd4095) begin n_err++; $display("FAIL max_last_addr: got %0d exp 4095", wr_addr); end
      n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_err++; $display("FAIL max_done: got done=%b hold=%b exp 1/0", done, cpu_hold); end
   endtask

   task automatic test_zero_gaps();
      for (int pass = 0; pass < 2; pass++) begin
         clear_log();
         pulse_start();
         for (int i = 0; i < 5; i++) begin
            idle($urandom_range(0, 3));
            send((i == 4 && pass == 1) ? 8'h01 : 8'h00);
         end
         idle(2);
         n_cmp++; if (log_a.size() !== 0) begin n_err++; $display("FAIL zero_writes%0d: got %0d exp 0", pass, log_a.size()); end
         n_cmp++;
         if ({done, err} !== ((pass == 0) ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL zero_flags%0d: got done/err=%b exp %b", pass, {done, err}, (pass == 0) ? 2'b10 : 2'b01);
         end
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      pulse_start();
      send_len(32'd8);
      send(8'hA0); send(8'hA1);
      s_valid = 1'b1; s_data = 8'hEE; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0;
      n_cmp++;
      if ({s_ready, wr_en, cpu_hold, done, err} !== 5'b00100 || wr_addr !== 32'd0 || wr_data !== 8'd0) begin
         n_err++;
         $display("FAIL midrst_vals: got rdy/en/hold/done/err=%b addr=%0h data=%02h exp 00100/0/00",
                  {s_ready, wr_en, cpu_hold, done, err}, wr_addr, wr_data);
      end
      idle(2);
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got %b exp 0", s_ready); end
      clear_log();
      pulse_start();
      send_len(32'd8);
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
      send(8'h9C);   // 0x10+..+0x17 = 0x9C
      idle(2);
      for (int i = 0; i < log_a.size(); i++)
         if (log_a[i] !== 32'(i) || log_d[i] !== 8'(8'h10 + i)) bad++;
      n_cmp++; if (log_a.size() !== 8 || bad !== 0) begin n_err++; $display("FAIL midrst_reload: got %0d writes %0d bad exp 8/0", log_a.size(), bad); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL midrst_done: got %b exp 1", done); end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      clear_log();
      pulse_start();
      send_len(32'd6);
      send(8'h01); send(8'h02); send(8'h03);
      start = 1'b1;
      send(8'h04);
      start = 1'b0;
      send(8'h05); send(8'h06);
      send(8'h15);
      idle(2);
      for (int i = 0; i < log_a.size(); i++)
         if (log_a[i] !== 32'(i) || log_d[i] !== 8'(i + 1)) bad++;
      n_cmp++; if (log_a.size() !== 6 || bad !== 0) begin n_err++; $display("FAIL b2b_seq: got %0d writes %0d bad exp 6/0", log_a.size(), bad); end
      n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_err++; $display("FAIL b2b_done: got done=%b hold=%b exp 1/0", done, cpu_hold); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      @(negedge clk);
      test_reset();
      test_normal();
      test_bad_csum();
      test_oversize();
      test_zero_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that fills instruction memory through its byte write port from a byte stream, the writer counterpart to the CPU's combinational instruction fetch. Parses a framed image (length header, payload, checksum), issues one byte write per payload byte at consecutive addresses from 0, and holds the core in reset until a complete, checksum-valid image has been written. Sits between the host/UART byte source and the IMEM write port; `cpu_hold` drives the core reset.

## Interface

- `MEM_NBYTE`, 4096: instruction memory size in bytes; largest accepted payload length.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle request to begin a load.
- `s_valid`  input  1  stream byte valid.
- `s_data`  input  8  stream byte.
- `s_ready`  output  1  loader accepts a byte this cycle.
- `wr_en`  output  1  IMEM byte write strobe.
- `wr_addr`  output  32  IMEM byte address.
- `wr_data`  output  8  IMEM byte data.
- `cpu_hold`  output  1  hold core in reset while high.
- `done`  output  1  image loaded and verified.
- `err`  output  1  load aborted: length too large or checksum mismatch.

## Operation

- Frame: 4-byte length N, little-endian (first byte = bits 7:0); then N payload bytes; then 1 checksum byte = sum of payload bytes mod 256.
- Transfer occurs on a rising edge where `s_valid && s_ready`; `s_ready` is a function of state only.
- States:
  - IDLE: `s_ready`=0, `cpu_hold`=1. `start` -> LEN.
  - LEN: `s_ready`=1; collect 4 bytes into 32-bit `len`. On 4th byte: N > `MEM_NBYTE` -> ERR; N == 0 -> CSUM; else -> DATA.
  - DATA: `s_ready`=1; each accepted byte written to address = byte index (0..N-1), added to 8-bit running sum; index counter 32 bits. After byte N-1 accepted -> CSUM.
  - CSUM: `s_ready`=1; accepted byte equal to sum -> DONE, else -> ERR.
  - DONE: `s_ready`=0, `cpu_hold`=0, `done`=1.
  - ERR: `s_ready`=0, `cpu_hold`=1, `err`=1.
- `start` in DONE or ERR -> LEN: clears `done`/`err`, re-asserts `cpu_hold`, zeroes byte counter, index and sum. `start` in LEN/DATA/CSUM ignored.
- Oversized length: no writes issued; payload bytes not consumed.
- Memory contents are never cleared by the loader; a failed load leaves partial data, core stays held.

## Timing

- Reset values: state IDLE; `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `err`=0.
- `rst` mid-load: next cycle is IDLE with reset values; counters and sum zeroed; in-flight byte discarded.
- `rst` has priority over `start`.
- `wr_en`/`wr_addr`/`wr_data` registered: one-cycle `wr_en` pulse in the cycle after each DATA handshake; `wr_addr`/`wr_data` hold their last values when `wr_en`=0.
- Back-to-back bytes (s_valid held high): one byte per cycle, one write per cycle, no bubbles.
- `done`/`err` and `cpu_hold` change in the cycle after the deciding handshake (checksum byte, or 4th length byte for oversize). The last payload write is always complete before `cpu_hold` falls.
- `start` to first possible handshake: 1 cycle (state = LEN on the next edge).

## Test plan

- Normal load: `start`, stream 04 00 00 00, 13 00 00 00, checksum 13 -> four writes at addr 0..3 with data 13,00,00,00 one cycle after each handshake; `done`=1, `cpu_hold`=0.
- Bad checksum: same frame with checksum 14 -> four writes occur; `err`=1, `done`=0, `cpu_hold`=1; `s_ready`=0 afterwards.
- Oversize: length 01 10 00 00 (4097) with `MEM_NBYTE`=4096 -> no `wr_en`, `err`=1 after 4th byte; exactly 4096 accepted, 4096 writes, last `wr_addr`=4095.
- Zero length plus gaps: length 0, checksum 00, `s_valid` toggled randomly -> no writes, `done`=1; a checksum of 01 instead -> `err`=1.
- Reset mid-DATA: `rst` after 2 of 8 payload bytes -> IDLE, all outputs at reset values; new `start` plus full frame loads from addr 0 and reaches `done`.
- Reload: `start` while in DONE -> `done`=0, `cpu_hold`=1 next cycle; `start` during DATA ignored (address sequence unbroken).
